// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, control FSM states
// and the decode helper that picks the iterative datapath.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SGE  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: shift-add multiply or restoring unsigned divide,
// one bit per cycle for WIDTH cycles after start.
module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST_STEP = (SHW + 1)'(WIDTH - 1);

    // acc: product / partial remainder; part: multiplier / dividend-quotient;
    // opnd: shifting multiplicand / fixed divisor
    logic [WIDTH-1:0] acc_q, part_q, opnd_q;
    logic [WIDTH-1:0] acc_d, part_d, opnd_d;
    logic [WIDTH:0]   shifted, diff;
    logic             div_q, rem_q, busy_q;
    logic [SHW:0]     count_q;

    always_comb begin
        acc_d   = acc_q;
        part_d  = part_q;
        opnd_d  = opnd_q;
        shifted = {acc_q, part_q[WIDTH-1]};
        diff    = shifted - {1'b0, opnd_q};
        if (div_q) begin
            // A clear borrow bit means the divisor fits; a zero divisor always fits,
            // which yields an all-ones quotient and leaves the dividend as remainder.
            if (!diff[WIDTH]) begin
                acc_d  = diff[WIDTH-1:0];
                part_d = {part_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d  = shifted[WIDTH-1:0];
                part_d = {part_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (part_q[0]) begin
                acc_d = acc_q + opnd_q;
            end
            part_d = part_q >> 1;
            opnd_d = opnd_q << 1;
        end
    end

    // The final step's value is presented combinationally so the caller can
    // register it on the same edge that ends the iteration.
    assign done   = busy_q && (count_q == LAST_STEP);
    assign result = (div_q && !rem_q) ? part_d : acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            part_q  <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            rem_q   <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
        end else if (start) begin
            acc_q   <= '0;
            part_q  <= a;
            opnd_q  <= b;
            div_q   <= is_div;
            rem_q   <= is_rem;
            busy_q  <= 1'b1;
            count_q <= '0;
        end else if (busy_q) begin
            acc_q   <= acc_d;
            part_q  <= part_d;
            opnd_q  <= opnd_d;
            count_q <= count_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready on both sides: single-cycle logic/arith/shift ops
// plus iterative MUL/DIVU/REMU through seq_alu_iter.
//
// Handshake: an operation is accepted on a rising edge where in_valid_i && in_ready_o;
// a result is consumed on a rising edge where out_valid_o && out_ready_i. Outputs hold
// steady while out_valid_o is high and out_ready_i is low.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic [1:0]       dbg_state_o
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic             accept, iter_start, iter_done;
    logic [WIDTH-1:0] iter_result;
    logic [WIDTH-1:0] simple_res, sum, dif;
    logic             simple_ovf, slt;
    logic [SHW-1:0]   shamt;

    assign in_ready_o  = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_DONE);
    assign dbg_state_o = state_q;
    assign accept      = in_valid_i && in_ready_o;
    assign iter_start  = accept && is_iter_op(op_i);

    assign sum   = src1_i + src2_i;
    assign dif   = src1_i - src2_i;
    assign slt   = $signed(src1_i) < $signed(src2_i);
    assign shamt = src2_i[SHW-1:0];

    always_comb begin
        simple_res = '0;
        simple_ovf = 1'b0;
        case (op_i)
            OP_AND: simple_res = src1_i & src2_i;
            OP_OR:  simple_res = src1_i | src2_i;
            OP_ADD: begin
                simple_res = sum;
                simple_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                             (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                simple_res = dif;
                simple_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                             (dif[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT: simple_res = {{(WIDTH-1){1'b0}}, slt};
            OP_SGE: simple_res = {{(WIDTH-1){1'b0}}, !slt};
            OP_SLL: simple_res = src1_i << shamt;
            OP_SRL: simple_res = src1_i >> shamt;
            OP_SRA: simple_res = $unsigned($signed(src1_i) >>> shamt);
            OP_NOR: simple_res = ~(src1_i | src2_i);
            default: begin
                simple_res = '0;
                simple_ovf = 1'b0;
            end
        endcase
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (iter_start),
        .is_div ((op_i == OP_DIVU) || (op_i == OP_REMU)),
        .is_rem (op_i == OP_REMU),
        .a      (src1_i),
        .b      (src2_i),
        .done   (iter_done),
        .result (iter_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)      state_d = is_iter_op(op_i) ? ST_ITER : ST_DONE;
            ST_ITER: if (iter_done)   state_d = ST_DONE;
            ST_DONE: if (out_ready_i) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Result registers only load when a result is produced, so they stay put through DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o   <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (accept && !is_iter_op(op_i)) begin
            result_o   <= simple_res;
            zero_o     <= (simple_res == '0);
            overflow_o <= simple_ovf;
        end else if ((state_q == ST_ITER) && iter_done) begin
            result_o   <= iter_result;
            zero_o     <= (iter_result == '0);
            overflow_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 and WIDTH=8 with an arithmetic reference model
// and a scoreboard that checks every consumed result.
module tb_seq_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [31:0] src1, src2;
    int          w_sel = 32;

    always #5 clk = ~clk;

    logic        iv32, iv8;
    logic        ready32, valid32, zero32, ovf32;
    logic        ready8, valid8, zero8, ovf8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic [1:0]  st32, st8;

    assign iv32 = in_valid && (w_sel == 32);
    assign iv8  = in_valid && (w_sel == 8);

    seq_alu #(.WIDTH(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv32), .in_ready_o(ready32), .op_i(op),
        .src1_i(src1), .src2_i(src2), .out_valid_o(valid32), .out_ready_i(out_ready),
        .result_o(res32), .zero_o(zero32), .overflow_o(ovf32), .dbg_state_o(st32)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(iv8), .in_ready_o(ready8), .op_i(op),
        .src1_i(src1[7:0]), .src2_i(src2[7:0]), .out_valid_o(valid8), .out_ready_i(out_ready),
        .result_o(res8), .zero_o(zero8), .overflow_o(ovf8), .dbg_state_o(st8)
    );

    logic        cur_ready, cur_valid, cur_zero, cur_ovf;
    logic [31:0] cur_res;
    assign cur_ready = (w_sel == 8) ? ready8 : ready32;
    assign cur_valid = (w_sel == 8) ? valid8 : valid32;
    assign cur_zero  = (w_sel == 8) ? zero8  : zero32;
    assign cur_ovf   = (w_sel == 8) ? ovf8   : ovf32;
    assign cur_res   = (w_sel == 8) ? {24'h0, res8} : res32;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {overflow, zero, result} from plain integer arithmetic at width w.
    function automatic logic [33:0] model(input int w, input logic [3:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, ua, ub, r;
        longint      sa, sb, full, lim;
        int          sh;
        logic        ovf;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'h0, a} & mask;
        ub   = {32'h0, b} & mask;
        lim  = longint'(1) << (w - 1);
        sa   = (((ua >> (w - 1)) & 64'd1) != 0) ? longint'(ua) - (lim * 2) : longint'(ua);
        sb   = (((ub >> (w - 1)) & 64'd1) != 0) ? longint'(ub) - (lim * 2) : longint'(ub);
        sh   = int'(ub % 64'(w));
        ovf  = 1'b0;
        r    = 64'd0;
        case (o)
            OP_AND:  r = ua & ub;
            OP_OR:   r = ua | ub;
            OP_ADD:  begin full = sa + sb; r = unsigned'(full); ovf = (full >= lim) || (full < -lim); end
            OP_SUB:  begin full = sa - sb; r = unsigned'(full); ovf = (full >= lim) || (full < -lim); end
            OP_SLT:  r = (sa < sb) ? 64'd1 : 64'd0;
            OP_SGE:  r = (sa >= sb) ? 64'd1 : 64'd0;
            OP_SLL:  r = ua << sh;
            OP_SRL:  r = ua >> sh;
            OP_SRA:  r = unsigned'(sa >>> sh);
            OP_NOR:  r = ~(ua | ub);
            OP_MUL:  r = ua * ub;
            OP_DIVU: r = (ub == 0) ? mask : ua / ub;
            OP_REMU: r = (ub == 0) ? ua : ua % ub;
            default: r = 64'd0;
        endcase
        r = r & mask;
        return {ovf, (r == 64'd0), r[31:0]};
    endfunction

    // Scoreboard: every handshaken result is checked against the queued expectation.
    always @(negedge clk) begin
        if (!rst && cur_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", cur_res);
            end else begin
                check("scoreboard", {cur_ovf, cur_zero, cur_res}, exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!cur_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        op = o; src1 = a; src2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [33:0] lit);
        logic [33:0] m;
        int          lat;
        logic        saw_ready;
        m = model(w_sel, o, a, b);
        check({name, "_model"}, m, lit);
        exp_q.push_back(m);
        send(o, a, b);
        lat = 1;
        saw_ready = cur_ready;
        while (!cur_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            saw_ready = saw_ready | cur_ready;
        end
        check({name, "_latency"}, 34'(lat), 34'(exp_lat));
        check({name, "_ready_low"}, {33'h0, saw_ready}, 34'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [33:0] m;
        logic        saw_valid;
        int          guard;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'h0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset32", {valid32, ready32, ovf32, zero32, res32[29:0]}, {2'b01, 32'h0});
        check("reset8",  {valid8, ready8, ovf8, zero8, 22'h0, res8}, {2'b01, 32'h0});

        // WIDTH=32 single-cycle ops
        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, {2'b10, 32'h8000_0000});
        run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 1, {2'b01, 32'h0});
        run_op("sra", OP_SRA, 32'h8000_0000, 32'h21, 1, {2'b00, 32'hC000_0000});
        run_op("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1, {2'b00, 32'h00F0_1234});
        run_op("or", OP_OR, 32'h0000_00F0, 32'h0000_000F, 1, {2'b00, 32'h0000_00FF});
        run_op("nor", OP_NOR, 32'h0, 32'h0, 1, {2'b00, 32'hFFFF_FFFF});
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 1, {2'b00, 32'h1});
        run_op("sge", OP_SGE, 32'hFFFF_FFFF, 32'h1, 1, {2'b01, 32'h0});
        run_op("sll", OP_SLL, 32'h1, 32'h24, 1, {2'b00, 32'h10});
        run_op("srl", OP_SRL, 32'h8000_0000, 32'd31, 1, {2'b00, 32'h1});
        run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 1, {2'b10, 32'h7FFF_FFFF});
        run_op("bad_op", 4'b0011, 32'h1234, 32'h5678, 1, {2'b01, 32'h0});

        // WIDTH=32 iterative ops
        run_op("mul_ones", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, {2'b00, 32'h1});
        run_op("mul", OP_MUL, 32'd12345, 32'd100, 33, {2'b00, 32'h0012_D644});
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 33, {2'b00, 32'd14});
        run_op("remu", OP_REMU, 32'd100, 32'd7, 33, {2'b00, 32'd2});
        run_op("divu_0", OP_DIVU, 32'd9, 32'd0, 33, {2'b00, 32'hFFFF_FFFF});
        run_op("remu_0", OP_REMU, 32'd9, 32'd0, 33, {2'b00, 32'd9});
        run_op("remu_zero", OP_REMU, 32'd14, 32'd7, 33, {2'b01, 32'h0});

        // Backpressure: result must hold for 5 cycles with the input side closed
        out_ready = 1'b0;
        m = model(32, OP_ADD, 32'd1, 32'd2);
        check("bp_model", m, {2'b00, 32'd3});
        exp_q.push_back(m);
        send(OP_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {cur_ovf, cur_zero, cur_res}, m);
            check("bp_flags", {32'h0, cur_valid, cur_ready}, {32'h0, 2'b10});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {32'h0, cur_valid, cur_ready}, {32'h0, 2'b01});

        // Reset in the middle of a multiply discards it
        send(OP_MUL, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset", {cur_valid, cur_ready, cur_ovf, cur_zero, cur_res[29:0]}, {2'b01, 32'h0});
        saw_valid = 1'b0;
        guard = 0;
        while (guard < 40) begin
            saw_valid = saw_valid | cur_valid;
            @(posedge clk); #1;
            guard++;
        end
        check("mid_reset_no_valid", {33'h0, saw_valid}, 34'h0);
        run_op("add_after_reset", OP_ADD, 32'd2, 32'd3, 1, {2'b00, 32'd5});

        // WIDTH=8
        w_sel = 8;
        #1;
        run_op("w8_add_ovf", OP_ADD, 32'h7F, 32'h1, 1, {2'b10, 32'h80});
        run_op("w8_mul_ones", OP_MUL, 32'hFF, 32'hFF, 9, {2'b00, 32'h1});
        run_op("w8_divu", OP_DIVU, 32'd100, 32'd7, 9, {2'b00, 32'd14});
        run_op("w8_remu_0", OP_REMU, 32'd9, 32'd0, 9, {2'b00, 32'd9});
        run_op("w8_sra", OP_SRA, 32'h80, 32'h09, 1, {2'b00, 32'hC0});

        repeat (2) @(posedge clk);
        check("queue_drained", 34'(exp_q.size()), 34'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
